// File: rtl/stream_packer.sv
// stream_packer
//   Packs 32-bit result words into 128-bit AXI-Stream beats (lane 0 first) and
//   queues the beats in a small FIFO in front of the M_AXIS master port.
//
//   A beat is closed when its fourth word arrives or when a word is marked as
//   the last word of a job. A closed beat sits for one cycle in a single-entry
//   pending stage before it enters the beat FIFO. The FIFO head drives the
//   stream outputs and is held stable under backpressure.
//
// Ports
//   clk        in   clock (AXIS_ACLK domain)
//   rst        in   synchronous active-high reset
//   word_v     in   result word valid
//   word_d     in   result word
//   word_fin   in   word_d is the last word of the job (qualified by word_v)
//   word_ready out  packer accepts word_d this cycle
//   dst_valid  out  M_AXIS_TVALID
//   dst_data   out  M_AXIS_TDATA (zero outside a valid beat)
//   dst_last   out  M_AXIS_TLAST (zero outside a valid beat)
//   dst_ready  in   M_AXIS_TREADY
//   busy       out  partial beat, pending beat or queued beats present
//   beat_cnt   out  beats emitted since reset, wraps

module stream_packer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              word_v,
  input  logic [31:0]       word_d,
  input  logic              word_fin,
  output logic              word_ready,
  output logic              dst_valid,
  output logic [127:0]      dst_data,
  output logic              dst_last,
  input  logic              dst_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  // Packing stage
  logic [1:0]   lane_q, lane_d;
  logic [127:0] pack_q, pack_d;

  // Pending stage: one closed beat waiting for FIFO space
  logic         pend_q, pend_d;
  logic [127:0] pend_data_q, pend_data_d;
  logic         pend_last_q, pend_last_d;

  // Beat FIFO, each entry is {last, data}
  logic [128:0]   mem_q [DEPTH];
  logic [128:0]   mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic         not_full;
  logic         accept;
  logic         complete;
  logic         push;
  logic         pop;
  logic [127:0] merged;

  // Full is judged on the registered count only, so a same-cycle pop never
  // frees space for the pending beat.
  assign not_full   = (count_q != FullCnt);
  assign word_ready = ~pend_q | not_full;
  assign accept     = word_v & word_ready;
  assign complete   = accept & ((lane_q == 2'd3) | word_fin);
  assign push       = pend_q & not_full;
  assign pop        = (count_q != '0) & dst_ready;

  // Pack register with the incoming word placed in the current lane. Lanes
  // above the current one are forced to zero so a short (fin) beat carries
  // nothing stale in its upper lanes.
  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(lane_q)) begin
        merged[32*i +: 32] = pack_q[32*i +: 32];
      end else if (i == int'(lane_q)) begin
        merged[32*i +: 32] = word_d;
      end
    end
  end

  always_comb begin
    lane_d      = lane_q;
    pack_d      = pack_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_last_d = pend_last_q;

    if (accept) begin
      if (complete) begin
        lane_d = 2'd0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        pack_d = merged;
      end
    end

    // A completion in the same cycle as a transfer reloads the pending stage.
    if (complete) begin
      pend_d      = 1'b1;
      pend_data_d = merged;
      pend_last_d = word_fin;
    end else if (push) begin
      pend_d = 1'b0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {pend_last_q, pend_data_q};
    end
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    beat_cnt_d = beat_cnt_q + CNT_W'(pop);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q      <= '0;
      pack_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_last_q <= pend_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    dst_valid = (count_q != '0);
    dst_data  = '0;
    dst_last  = 1'b0;
    if (dst_valid) begin
      dst_data = mem_q[rd_ptr_q][127:0];
      dst_last = mem_q[rd_ptr_q][128];
    end
  end

  assign busy     = (lane_q != 2'd0) | pend_q | (count_q != '0);
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_stream_packer.sv
module tb_stream_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         word_v;
  logic [31:0]  word_d;
  logic         word_fin;
  logic         word_ready;
  logic         dst_valid;
  logic [127:0] dst_data;
  logic         dst_last;
  logic         dst_ready;
  logic         busy;
  logic [15:0]  beat_cnt;

  stream_packer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .word_v    (word_v),
    .word_d    (word_d),
    .word_fin  (word_fin),
    .word_ready(word_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_last  (dst_last),
    .dst_ready (dst_ready),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the accepted word stream is cut into beats of up to four
  // words, closed early by fin; expected beats are queued as {last, data}.
  logic [128:0] exp_q[$];
  logic [127:0] m_cur;
  int           m_lane;
  int           acc_cnt;
  logic         prev_stall;
  logic [127:0] prev_data;
  logic         send_done;

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cur  = '0;
    m_lane = 0;
  endtask

  // Inputs are sampled mid-cycle, so everything seen here holds at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && dst_valid) check("head_stable", {1'b0, dst_data}, {1'b0, prev_data});
      if (!dst_valid) check("idle_zero", {dst_last, dst_data}, '0);
      if (dst_valid && dst_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", {dst_last, dst_data}, 129'h0 - 1);
        end else begin
          check("beat", {dst_last, dst_data}, exp_q.pop_front());
        end
      end
      prev_stall = dst_valid && !dst_ready;
      prev_data  = dst_data;
      if (word_v && word_ready) begin
        acc_cnt++;
        m_cur[32*m_lane +: 32] = word_d;
        m_lane++;
        if (m_lane == 4 || word_fin) begin
          exp_q.push_back({word_fin, m_cur});
          m_cur  = '0;
          m_lane = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word is taken.
  task automatic send(input logic [31:0] d, input logic f);
    int n = 0;
    word_v   = 1'b1;
    word_d   = d;
    word_fin = f;
    @(negedge clk);
    while (!word_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!word_ready) check("send_timeout", {128'h0, word_ready}, 129'h1);
    @(posedge clk);
    #1;
    word_v   = 1'b0;
    word_fin = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    dst_ready = 1'b1;
    while ((exp_q.size() != 0 || dst_valid || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_busy", {128'h0, busy}, 129'h0);
  endtask

  initial begin
    rst       = 1'b1;
    word_v    = 1'b0;
    word_d    = '0;
    word_fin  = 1'b0;
    dst_ready = 1'b1;
    acc_cnt   = 0;
    send_done = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_word_ready", {128'h0, word_ready}, 129'h1);
    check("rst_dst_valid", {128'h0, dst_valid}, 129'h0);
    check("rst_dst_out", {dst_last, dst_data}, '0);
    check("rst_busy", {128'h0, busy}, 129'h0);
    check("rst_beat_cnt", {113'h0, beat_cnt}, 129'h0);
    rst = 1'b0;

    // Words 1..8, fin on 8, with latency check on the first beat
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
    @(negedge clk);
    check("lat_v_early", {128'h0, dst_valid}, 129'h0);
    @(negedge clk);
    check("lat_v_two", {128'h0, dst_valid}, 129'h1);
    @(posedge clk);
    #1;
    for (int i = 5; i <= 8; i++) send(32'(i), i == 8);
    drain();
    check("t1_beat_cnt", {113'h0, beat_cnt}, 129'd2);

    // Six words, fin on the sixth: short second beat
    for (int i = 0; i < 6; i++) send(32'hA0 + 32'(i), i == 5);
    drain();
    check("t2_beat_cnt", {113'h0, beat_cnt}, 129'd4);

    // Backpressure: 24 words into a stalled sink
    dst_ready = 1'b0;
    acc_cnt   = 0;
    send_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send($urandom(), i == 23);
        send_done = 1'b1;
      end
    join_none
    repeat (60) @(posedge clk);
    #1;
    check("bp_accepted", acc_cnt, 20);
    check("bp_word_ready", {128'h0, word_ready}, 129'h0);
    check("bp_busy", {128'h0, busy}, 129'h1);
    check("bp_valid", {128'h0, dst_valid}, 129'h1);
    check("bp_beat_cnt", {113'h0, beat_cnt}, 129'd4);
    dst_ready = 1'b1;
    for (int n = 0; n < 300 && !send_done; n++) begin
      @(posedge clk);
      #1;
    end
    check("bp_send_done", {128'h0, send_done}, 129'h1);
    drain();
    check("bp_accepted_all", acc_cnt, 24);
    check("bp_beat_cnt_end", {113'h0, beat_cnt}, 129'd10);

    // dst_ready toggling against continuous input
    send_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send($urandom(), (i == 39) || ($urandom_range(0, 7) == 0));
        send_done = 1'b1;
      end
      begin
        for (int n = 0; n < 2000 && !send_done; n++) begin
          @(posedge clk);
          #1;
          dst_ready = ~dst_ready;
        end
      end
    join
    drain();

    // Reset with two beats queued and a half-filled beat
    dst_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), 1'b0);
    send(32'h200, 1'b0);
    send(32'h201, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rr_dst_valid", {128'h0, dst_valid}, 129'h0);
    check("rr_busy", {128'h0, busy}, 129'h0);
    check("rr_beat_cnt", {113'h0, beat_cnt}, 129'h0);
    check("rr_word_ready", {128'h0, word_ready}, 129'h1);
    dst_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h300 + 32'(i), 1'b0);
    drain();
    check("rr_one_beat", {113'h0, beat_cnt}, 129'd1);

    // Single word with fin
    send(32'hDEADBEEF, 1'b1);
    drain();
    check("single_busy", {128'h0, busy}, 129'h0);
    check("single_beat_cnt", {113'h0, beat_cnt}, 129'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_packer.md
Name: stream_packer

Overview:
- Downstream stage between the core result outputs and the M_AXIS master port.
- Accepts 32-bit result words through a valid/ready handshake and packs 4 words into each 128-bit stream beat, lane 0 first.
- Queues packed beats in a small beat FIFO and drives the AXI-Stream master valid/data/last signals under backpressure.
- Replaces the fixed-count stream_v/stream_a sequencing with a word-driven, backpressure-correct path.

Parameters:
- DEPTH, 4, number of 128-bit beats held in the output FIFO (power of 2, ≥2).
- CNT_W, 16, width of the emitted-beat counter.

Ports:
- clk  in  1  single clock (AXIS_ACLK domain).
- rst  in  1  synchronous, active-high reset.
- word_v  in  1  result word valid.
- word_d  in  32  result word.
- word_fin  in  1  marks word_d as the last word of the job; qualified by word_v.
- word_ready  out  1  packer can accept word_d this cycle.
- dst_valid  out  1  M_AXIS_TVALID.
- dst_data  out  128  M_AXIS_TDATA.
- dst_last  out  1  M_AXIS_TLAST.
- dst_ready  in  1  M_AXIS_TREADY.
- busy  out  1  packer holds a partial beat, a pending beat, or FIFO data.
- beat_cnt  out  CNT_W  beats emitted since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset values:
  - word_ready=1, dst_valid=0, dst_data=0, dst_last=0, busy=0, beat_cnt=0.
  - lane=0, pack register=0, pend=0, FIFO empty.
  - Reset mid-operation discards all partial, pending and queued data within one cycle.
- Accept condition: word_v & word_ready. The accepted word is written to pack lane `lane` (bits [32*lane+31:32*lane]) and lane increments.
- Beat completion: the accepted word lands in lane 3, or word_fin=1.
  - Next edge: pend=1; pend_data holds the pack register with the new word included and unfilled upper lanes forced to 0; pend_last=word_fin.
  - The pack register clears and lane returns to 0.
- Pend transfer: each cycle, if pend & (FIFO count < DEPTH), pend_data/pend_last are pushed into the FIFO and pend clears.
  - Full is judged on the registered count. A pop in the same cycle does not enable a push.
- word_ready = ~pend | (count < DEPTH).
  - Full-rate input therefore sustains 1 beat per 4 cycles with no bubbles.
  - A new completion in the same cycle as a pend transfer reloads pend.
- FIFO output:
  - dst_valid = count != 0.
  - dst_data and dst_last come from the head entry. Outside a valid beat they are 0.
- Pop rule:
  - Pop on dst_valid & dst_ready; beat_cnt increments on each pop.
  - Head data must stay stable while dst_valid=1 & dst_ready=0.
- Simultaneous push and pop: the count is unchanged and both operations complete.
- Latency: the word completing a beat appears on dst_data 2 cycles after acceptance when the FIFO is empty (edge 1 → pend, edge 2 → FIFO).
- word_fin on lane 0: emits a beat holding only that word, with last=1.
- busy = (lane != 0) | pend | (count != 0).
- word_v=0 changes nothing. word_fin is ignored when word_v=0.

Test Plan:
- Reset, then 8 words 0x1..0x8, word_fin on 0x8, dst_ready=1 → 2 beats:
  - 0x00000004_00000003_00000002_00000001 with last=0.
  - 0x00000008_00000007_00000006_00000005 with last=1.
  - First beat has dst_valid 2 cycles after the 4th word; beat_cnt=2.
- 6 words 0xA0..0xA5, word_fin on 0xA5 → beat 2 = 0x0_0_000000A5_000000A4 with last=1.
- dst_ready=0 while streaming 24 words with DEPTH=4:
  - word_ready drops after 5 beats are formed (4 in FIFO plus pend).
  - dst_data stays constant throughout.
  - Releasing dst_ready drains all 6 beats in order with no loss or duplication.
- dst_ready toggling every cycle against continuous word_v:
  - Every word appears exactly once, in order.
  - No beat appears while dst_valid=0.
- rst pulsed 1 cycle after the 2nd of 4 words, with 2 beats queued → next cycle dst_valid=0, busy=0, beat_cnt=0, word_ready=1.
  - 4 new words then yield exactly one beat containing only them.
- Single word 0xDEADBEEF with word_fin → one beat 0x..._DEADBEEF with upper lanes 0 and last=1.
  - busy returns to 0 after the pop.
